pipe_buf_stage: RTL and testbench

- Parametrised valid/ready pipeline buffer that replaces the fixed single-entry inter-stage registers (fetch→id, lsu→wb) in the core.
- Holds up to DEPTH payloads in a circular buffer.
- Adds: synchronous flush for branch/trap redirect, optional same-cycle bypass when empty, occupancy output for perf counters.
- One instance per stage boundary; payload is an opaque packed vector.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_buf_stage_if.sv | 11 +
 rtl/pipe_ptr.sv | 40 ++++
 rtl/pipe_buf_stage.sv | 115 +++++++++++
 tb/tb_pipe_buf_stage.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared payload types for the pipeline stage buffers, plus the pointer-width helper.
package pipe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_id_payload_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [1:0]  reg_wdata_sel;
        logic [31:0] csr_rdata;
        logic [31:0] dmem_rdata;
        logic        reg_wen;
        logic [4:0]  reg_waddr;
    } lsu_wb_payload_t;

    localparam int FETCH_ID_W = $bits(fetch_id_payload_t);
    localparam int LSU_WB_W   = $bits(lsu_wb_payload_t);

    // A single-entry buffer still needs a 1-bit pointer to keep vectors legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buf_stage_if.sv
// Valid/ready/data stream bundle; master drives valid and data, slave drives ready.
interface pipe_buf_stage_if #(
    parameter int WIDTH = 64
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_ptr.sv
// Circular-buffer pointer: advances on inc, wraps DEPTH-1 -> 0, clear returns it to 0.
module pipe_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // Explicit wrap so non-power-of-two depths never address past the last entry.
    always_comb begin
        ptr_next = ptr_reg;
        if (clear) begin
            ptr_next = '0;
        end else if (inc) begin
            ptr_next = (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/pipe_buf_stage.sv
// DEPTH-entry valid/ready stage buffer with flush, optional empty bypass and occupancy count.
// DEPTH=1 alternates push and pop (half throughput); use DEPTH>=2 for one transfer per cycle.
module pipe_buf_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_buf_stage_if.slave      up,
    pipe_buf_stage_if.master     dn,
    output logic [CNT_W-1:0]     count
);

    localparam int              PTR_W    = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]            count_reg;
    logic [CNT_W-1:0]            count_next;
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W-1:0]            wr_ptr;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    logic empty;
    logic full;
    logic pass;
    logic push;
    logic pop;
    logic thru;
    logic wr_en;
    logic rd_en;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == FULL_CNT);
    assign pass  = (BYPASS != 0) && empty;

    // Ready comes from held state only, so no combinational path from dn.ready.
    assign up.ready = !full && !flush;
    assign dn.valid = !flush && (pass ? up.valid : !empty);
    assign dn.data  = pass ? up.data : mem_q[rd_ptr];

    assign push  = up.valid && up.ready;
    assign pop   = dn.valid && dn.ready;
    assign thru  = pass && push && pop;
    assign wr_en = push && !thru;
    assign rd_en = pop && !thru;

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

    pipe_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    pipe_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .inc   (rd_en),
        .ptr   (rd_ptr)
    );

    // Storage is zeroed on reset but deliberately left untouched by flush.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                entry_reg <= '0;
            end else if (wr_en && (wr_ptr == PTR_W'(gi))) begin
                entry_reg <= up.data;
            end
        end

        assign mem_q[gi] = entry_reg;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(wr_en && full))
                else $error("pipe_buf_stage: write into full buffer");
            assert (!(rd_en && empty))
                else $error("pipe_buf_stage: read from empty buffer");
            assert (count_reg <= FULL_CNT)
                else $error("pipe_buf_stage: occupancy above DEPTH");
        end
    end
`endif

endmodule

// File: tb/tb_pipe_buf_stage.sv
// Directed bench for three buffer configurations with a per-instance queue scoreboard.
module tb_pipe_buf_stage;

    typedef logic [15:0] q_t[$];

    logic       clk;
    logic       rst_n;
    logic       fl_a, fl_b, fl_c;
    logic [1:0] cnt_a, cnt_b, cnt_c;
    bit         chk_en;
    int         tests;
    int         fails;
    q_t         qa, qb, qc;

    pipe_buf_stage_if #(.WIDTH(16)) up_a ();
    pipe_buf_stage_if #(.WIDTH(16)) dn_a ();
    pipe_buf_stage_if #(.WIDTH(16)) up_b ();
    pipe_buf_stage_if #(.WIDTH(16)) dn_b ();
    pipe_buf_stage_if #(.WIDTH(16)) up_c ();
    pipe_buf_stage_if #(.WIDTH(16)) dn_c ();

    pipe_buf_stage #(.WIDTH(16), .DEPTH(2), .BYPASS(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(fl_a), .up(up_a), .dn(dn_a), .count(cnt_a)
    );
    pipe_buf_stage #(.WIDTH(16), .DEPTH(3), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(fl_b), .up(up_b), .dn(dn_b), .count(cnt_b)
    );
    pipe_buf_stage #(.WIDTH(16), .DEPTH(2), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(fl_c), .up(up_c), .dn(dn_c), .count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    // Compare one instance against its queue model, then advance the model for this edge.
    task automatic step_model(input string n, input int depth, input bit byp, ref q_t q,
                              input logic fl, input logic iv, input logic [15:0] id,
                              input logic ordy, input logic irdy, input logic ov,
                              input logic [15:0] od, input logic [1:0] cnt);
        logic er, ev, pass;
        logic [15:0] ed;
        er   = (q.size() != depth) && !fl;
        pass = byp && (q.size() == 0);
        ev   = !fl && (pass ? iv : (q.size() != 0));
        ed   = pass ? id : ((q.size() != 0) ? q[0] : 16'h0);
        chk({n, "_i_ready"}, 32'(irdy), 32'(er));
        chk({n, "_o_valid"}, 32'(ov), 32'(ev));
        chk({n, "_count"}, 32'(cnt), 32'(q.size()));
        if (ev) chk({n, "_o_data"}, 32'(od), 32'(ed));
        if (!rst_n || fl) begin
            q.delete();
        end else if (pass) begin
            if (iv && !ordy) q.push_back(id);
        end else begin
            if (ev && ordy) void'(q.pop_front());
            if (iv && er) q.push_back(id);
        end
    endtask

    task automatic tick();
        #1;
        if (chk_en) begin
            step_model("a", 2, 1'b0, qa, fl_a, up_a.valid, up_a.data, dn_a.ready,
                       up_a.ready, dn_a.valid, dn_a.data, cnt_a);
            step_model("b", 3, 1'b0, qb, fl_b, up_b.valid, up_b.data, dn_b.ready,
                       up_b.ready, dn_b.valid, dn_b.data, cnt_b);
            step_model("c", 2, 1'b1, qc, fl_c, up_c.valid, up_c.data, dn_c.ready,
                       up_c.ready, dn_c.valid, dn_c.data, cnt_c);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        chk_en = 1'b0;
        rst_n = 1'b0;
        fl_a = 1'b0; fl_b = 1'b0; fl_c = 1'b0;
        up_a.valid = 1'b0; up_a.data = '0; dn_a.ready = 1'b0;
        up_b.valid = 1'b0; up_b.data = '0; dn_b.ready = 1'b0;
        up_c.valid = 1'b0; up_c.data = '0; dn_c.ready = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("a_rst_data", 32'(dn_a.data), 32'h0);
        chk("b_rst_data", 32'(dn_b.data), 32'h0);
        tick();

        // Fill DEPTH=2 with backpressure, refuse a third, then drain in order
        up_a.valid = 1'b1; up_a.data = 16'h000A; tick();
        up_a.data = 16'h000B; tick();
        up_a.data = 16'h000C; tick();
        up_a.valid = 1'b0; dn_a.ready = 1'b1;
        tick(); tick(); tick();
        dn_a.ready = 1'b0;

        // Streaming 1..10 through DEPTH=3 exercises pointer wrap
        dn_b.ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            up_b.valid = 1'b1; up_b.data = 16'(i); tick();
        end
        up_b.valid = 1'b0;
        tick(); tick();

        // Random traffic with backpressure and occasional flush
        for (int i = 0; i < 80; i++) begin
            up_b.valid = 1'($urandom_range(0, 1));
            up_b.data  = 16'($urandom_range(0, 65535));
            dn_b.ready = 1'($urandom_range(0, 2) != 0);
            fl_b       = ($urandom_range(0, 15) == 0);
            tick();
        end
        fl_b = 1'b0; up_b.valid = 1'b0; dn_b.ready = 1'b1;
        tick(); tick(); tick(); tick();
        dn_b.ready = 1'b0;

        // Flush a full buffer while offering 0x55
        up_a.valid = 1'b1; up_a.data = 16'h0001; tick();
        up_a.data = 16'h0002; tick();
        fl_a = 1'b1; up_a.data = 16'h0055; tick();
        fl_a = 1'b0; up_a.valid = 1'b0; tick();
        up_a.valid = 1'b1; up_a.data = 16'h0066; dn_a.ready = 1'b1; tick();
        up_a.valid = 1'b0; tick(); tick();
        dn_a.ready = 1'b0;

        // Bypass pass-through, then store-and-forward once non-empty
        up_c.valid = 1'b1; up_c.data = 16'h0077; dn_c.ready = 1'b1; tick();
        up_c.valid = 1'b0; tick();
        up_c.valid = 1'b1; up_c.data = 16'h0088; dn_c.ready = 1'b0; tick();
        up_c.data = 16'h0099; dn_c.ready = 1'b1; tick();
        up_c.valid = 1'b0; tick(); tick();
        fl_c = 1'b1; up_c.valid = 1'b1; up_c.data = 16'h00AA; tick();
        fl_c = 1'b0; up_c.valid = 1'b0; tick();
        dn_c.ready = 1'b0;

        // Reset mid-operation with a push pending
        up_a.valid = 1'b1; up_a.data = 16'h0031; tick();
        up_a.data = 16'h0032; rst_n = 1'b0; tick();
        rst_n = 1'b1; up_a.valid = 1'b0; tick();
        dn_a.ready = 1'b1; tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
